multi_issue_decode_buf: RTL and testbench
=========================================

Name: multi_issue_decode_buf

Overview:
- Parametrised successor to the single-lane combinational ALU decoder.
- Buffers fetched instructions in a DEPTH-entry FIFO and decodes up to LANES instructions per cycle from the FIFO head into the existing 8-bit *_CONTROL codes.
- Applies dual-issue pairing rules and presents a valid/ready issue interface to the execute stage.
- Sits between fetch and issue/execute.

Parameters:
- LANES, 2: lanes pushed/issued per cycle. Legal values: 1 or 2.
- DEPTH, 8: FIFO entries. Power of 2, and DEPTH >= 2*LANES.
- XLEN, 32: instruction and PC width.
- CTRL_W, 8: alucontrol width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered instructions
- in_valid  in  LANES  per-lane push valid; must be contiguous from lane 0
- in_inst  in  LANES*XLEN  instruction words; lane 0 is oldest
- in_pc  in  LANES*XLEN  PCs
- in_ready  out  1  high when free slots >= LANES
- out_valid  out  LANES  per-lane issue valid; contiguous from lane 0
- out_inst  out  LANES*XLEN  head instructions
- out_pc  out  LANES*XLEN  head PCs
- out_alucontrol  out  LANES*CTRL_W  decoded control codes
- out_dst  out  LANES*5  destination register; 0 if none
- issue_ready  in  1  execute accepts all asserted out_valid lanes this cycle

Behaviour:
- Reset (rst high at an edge):
  - Read/write pointers and count cleared.
  - out_valid=0; all out_* data forced to 0; in_ready=1 from the next cycle.
- Push:
  - Accepted only when in_ready=1. Entries written = popcount(in_valid), in lane order.
  - Pushes while in_ready=0 are ignored.
  - Non-contiguous in_valid (e.g. 2'b10) is illegal; the bench asserts on it.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Count is $clog2(DEPTH+1) bits.
  - Push and pop in the same cycle are both honoured: count += pushed - popped.
- Latency:
  - An entry pushed at edge t is visible on out_* in cycle t+1.
  - Head read, decode and pairing are combinational from FIFO storage; no output register.
- Lane validity:
  - out_valid[0] = count >= 1.
  - out_valid[1] = count >= 2 AND pair_ok.
- pair_ok is false if any of the following holds:
  - (a) dst0 != 0 and (lane1 rs == dst0 or lane1 rt == dst0).
  - (b) both lanes are HILO-class: MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO/MADD*/MSUB*.
  - (c) lane 0 alucontrol is DIV_CONTROL or DIVU_CONTROL.
- Pop: when issue_ready=1, pop popcount(out_valid) entries. issue_ready with out_valid=0 has no effect.
- Decode, per lane (opcode=inst[31:26], funct=inst[5:0]):
  - SPECIAL (000000): by funct, producing the full R-type set already in use.
    - funct SRL with inst[21]=1 → ROTR_CONTROL.
    - funct SRLV with inst[6]=1 → ROTRV_CONTROL.
  - SPECIAL2 (011100): MUL, MADD, MADDU, MSUB, MSUBU, CLO, CLZ.
  - SPECIAL3 (011111): EXT, INS; BSHFL funct with sa=10000 → SEB, 11000 → SEH, 00010 → WSBH.
  - I-type: ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI.
  - Anything else → 8'h00.
- Destination:
  - rd: SPECIAL writers (not MULT/MULTU/DIV/DIVU/MTHI/MTLO/JR), MUL/CLO/CLZ, SEB/SEH/WSBH.
  - rt: I-type ALU ops, loads, EXT/INS.
  - 31: JAL.
  - Otherwise 0.
- Flush:
  - Pointers and count cleared at the edge.
  - Pushes and pops in the flush cycle are dropped.
  - out_valid=0 in the next cycle.
  - Flush has priority over push/pop; rst has priority over flush.
- Full boundary: in_ready = (DEPTH - count) >= LANES. With count = DEPTH-1 and LANES=2, in_ready=0 even for a single-lane push.
- Empty boundary: out_valid=0; out data is don't-care but driven 0.

Decomposition:
- Shared package (extends defines2):
  - opcode/funct/sa constants for SPECIAL2, SPECIAL3 and BSHFL.
  - the existing *_CONTROL codes.
  - HILO-class predicate function.
  - lane_t struct {inst, pc, ctrl, dst}.
- One sub-module: inst_lane_decode, a combinational single-instruction decode to {ctrl, dst, rs, rt, is_hilo, is_div}, instantiated LANES times.

Test Plan:
- Reset: assert rst 2 cycles → out_valid=00, in_ready=1, and no issue after release with in_valid=0.
- Independent pair: push 0x012A4020 (add t0,t1,t2) + 0x358B0005 (ori t3,t4,5), issue_ready=1 → next cycle out_valid=11, ctrl = ADD_CONTROL/OR_CONTROL, dst = 8/11, and both pop.
- RAW split: push 0x012A4020 + 0x350B0001 (ori t3,t0,1) → out_valid=01. After the pop, ori sits in lane 0 with OR_CONTROL.
- Shift/rotate and HILO pairing:
  - 0x00094042 → SRL_CONTROL; 0x00294042 → ROTR_CONTROL.
  - pair mult t1,t2 + mflo t0 → out_valid=01.
- Fill and wrap (DEPTH=8, issue_ready=0): push pairs → in_ready drops at count 8. A single push then reaches count... (not reachable with pairs); drain with issue_ready=1 across the pointer wrap and check FIFO order is preserved.
- Flush: count=5 with a simultaneous push → count=0 and out_valid=00 next cycle, the pushed entries never appear, and in_ready=1.

Source files
------------

// File: rtl/multi_issue_decode_buf_pkg.sv
// Shared definitions for the multi-issue decode buffer: MIPS opcode/funct/sa
// field values, the 8-bit *_CONTROL alucontrol codes, the HILO-class
// predicate and the per-lane head record.
package multi_issue_decode_buf_pkg;

  localparam int ISA_W  = 32;
  localparam int CTRL_WP = 8;

  // Major opcodes
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_SPECIAL3 = 6'b011111;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LBU      = 6'b100100;
  localparam logic [5:0] OP_LHU      = 6'b100101;

  // SPECIAL funct
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // SPECIAL2 funct
  localparam logic [5:0] F2_MADD  = 6'b000000;
  localparam logic [5:0] F2_MADDU = 6'b000001;
  localparam logic [5:0] F2_MUL   = 6'b000010;
  localparam logic [5:0] F2_MSUB  = 6'b000100;
  localparam logic [5:0] F2_MSUBU = 6'b000101;
  localparam logic [5:0] F2_CLZ   = 6'b100000;
  localparam logic [5:0] F2_CLO   = 6'b100001;

  // SPECIAL3 funct and BSHFL sub-op (sa field)
  localparam logic [5:0] F3_EXT   = 6'b000000;
  localparam logic [5:0] F3_INS   = 6'b000100;
  localparam logic [5:0] F3_BSHFL = 6'b100000;
  localparam logic [4:0] SA_WSBH  = 5'b00010;
  localparam logic [4:0] SA_SEB   = 5'b10000;
  localparam logic [4:0] SA_SEH   = 5'b11000;

  // alucontrol codes (8'h00 means "no ALU operation")
  localparam logic [7:0] AND_CONTROL   = 8'b0010_0100;
  localparam logic [7:0] OR_CONTROL    = 8'b0010_0101;
  localparam logic [7:0] XOR_CONTROL   = 8'b0010_0110;
  localparam logic [7:0] NOR_CONTROL   = 8'b0010_0111;
  localparam logic [7:0] LUI_CONTROL   = 8'b0000_1111;
  localparam logic [7:0] SLL_CONTROL   = 8'b0111_1100;
  localparam logic [7:0] SRL_CONTROL   = 8'b0000_0010;
  localparam logic [7:0] SRA_CONTROL   = 8'b0000_0011;
  localparam logic [7:0] SLLV_CONTROL  = 8'b0000_0100;
  localparam logic [7:0] SRLV_CONTROL  = 8'b0000_0110;
  localparam logic [7:0] SRAV_CONTROL  = 8'b0000_0111;
  localparam logic [7:0] MFHI_CONTROL  = 8'b0001_0000;
  localparam logic [7:0] MTHI_CONTROL  = 8'b0001_0001;
  localparam logic [7:0] MFLO_CONTROL  = 8'b0001_0010;
  localparam logic [7:0] MTLO_CONTROL  = 8'b0001_0011;
  localparam logic [7:0] MULT_CONTROL  = 8'b0001_1000;
  localparam logic [7:0] MULTU_CONTROL = 8'b0001_1001;
  localparam logic [7:0] DIV_CONTROL   = 8'b0001_1010;
  localparam logic [7:0] DIVU_CONTROL  = 8'b0001_1011;
  localparam logic [7:0] ADD_CONTROL   = 8'b0010_0000;
  localparam logic [7:0] ADDU_CONTROL  = 8'b0010_0001;
  localparam logic [7:0] SUB_CONTROL   = 8'b0010_0010;
  localparam logic [7:0] SUBU_CONTROL  = 8'b0010_0011;
  localparam logic [7:0] SLT_CONTROL   = 8'b0010_1010;
  localparam logic [7:0] SLTU_CONTROL  = 8'b0010_1011;
  localparam logic [7:0] ROTR_CONTROL  = 8'h40;
  localparam logic [7:0] ROTRV_CONTROL = 8'h41;
  localparam logic [7:0] MUL_CONTROL   = 8'h50;
  localparam logic [7:0] MADD_CONTROL  = 8'h51;
  localparam logic [7:0] MADDU_CONTROL = 8'h52;
  localparam logic [7:0] MSUB_CONTROL  = 8'h53;
  localparam logic [7:0] MSUBU_CONTROL = 8'h54;
  localparam logic [7:0] CLO_CONTROL   = 8'h55;
  localparam logic [7:0] CLZ_CONTROL   = 8'h56;
  localparam logic [7:0] EXT_CONTROL   = 8'h60;
  localparam logic [7:0] INS_CONTROL   = 8'h61;
  localparam logic [7:0] SEB_CONTROL   = 8'h62;
  localparam logic [7:0] SEH_CONTROL   = 8'h63;
  localparam logic [7:0] WSBH_CONTROL  = 8'h64;

  // Ops that read or write the HI/LO pair; two of them cannot issue together.
  function automatic logic is_hilo_ctrl(input logic [7:0] c);
    case (c)
      MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL,
      MTHI_CONTROL, MTLO_CONTROL, MFHI_CONTROL, MFLO_CONTROL,
      MADD_CONTROL, MADDU_CONTROL, MSUB_CONTROL, MSUBU_CONTROL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Decoded view of one FIFO head entry.
  typedef struct packed {
    logic [ISA_W-1:0]   inst;
    logic [ISA_W-1:0]   pc;
    logic [CTRL_WP-1:0] ctrl;
    logic [4:0]         dst;
  } lane_t;

endpackage

// File: rtl/multi_issue_decode_buf_inst_lane_decode.sv
// Combinational decode of one MIPS instruction.
//   inst    : instruction word
//   ctrl    : alucontrol code (8'h00 when not an ALU op)
//   dst     : destination GPR, 0 when the instruction writes none
//   rs, rt  : source register fields
//   is_hilo : instruction is HILO-class
//   is_div  : instruction is DIV or DIVU
module inst_lane_decode
  import multi_issue_decode_buf_pkg::*;
(
  input  logic [ISA_W-1:0]   inst,
  output logic [CTRL_WP-1:0] ctrl,
  output logic [4:0]         dst,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic               is_hilo,
  output logic               is_div
);

  logic [5:0] opcode, funct;
  logic [4:0] rd, sa;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign sa     = inst[10:6];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    ctrl = '0;
    dst  = '0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_SLL:   ctrl = SLL_CONTROL;
          F_SRL:   ctrl = inst[21] ? ROTR_CONTROL : SRL_CONTROL;
          F_SRA:   ctrl = SRA_CONTROL;
          F_SLLV:  ctrl = SLLV_CONTROL;
          F_SRLV:  ctrl = inst[6] ? ROTRV_CONTROL : SRLV_CONTROL;
          F_SRAV:  ctrl = SRAV_CONTROL;
          F_MFHI:  ctrl = MFHI_CONTROL;
          F_MTHI:  ctrl = MTHI_CONTROL;
          F_MFLO:  ctrl = MFLO_CONTROL;
          F_MTLO:  ctrl = MTLO_CONTROL;
          F_MULT:  ctrl = MULT_CONTROL;
          F_MULTU: ctrl = MULTU_CONTROL;
          F_DIV:   ctrl = DIV_CONTROL;
          F_DIVU:  ctrl = DIVU_CONTROL;
          F_ADD:   ctrl = ADD_CONTROL;
          F_ADDU:  ctrl = ADDU_CONTROL;
          F_SUB:   ctrl = SUB_CONTROL;
          F_SUBU:  ctrl = SUBU_CONTROL;
          F_AND:   ctrl = AND_CONTROL;
          F_OR:    ctrl = OR_CONTROL;
          F_XOR:   ctrl = XOR_CONTROL;
          F_NOR:   ctrl = NOR_CONTROL;
          F_SLT:   ctrl = SLT_CONTROL;
          F_SLTU:  ctrl = SLTU_CONTROL;
          default: ctrl = '0;
        endcase
        // Everything decoded here writes rd except the ops that only touch HI/LO.
        case (funct)
          F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO: dst = '0;
          default: dst = (ctrl != '0) ? rd : 5'd0;
        endcase
      end
      OP_SPECIAL2: begin
        case (funct)
          F2_MADD:  ctrl = MADD_CONTROL;
          F2_MADDU: ctrl = MADDU_CONTROL;
          F2_MSUB:  ctrl = MSUB_CONTROL;
          F2_MSUBU: ctrl = MSUBU_CONTROL;
          F2_MUL:   begin ctrl = MUL_CONTROL; dst = rd; end
          F2_CLO:   begin ctrl = CLO_CONTROL; dst = rd; end
          F2_CLZ:   begin ctrl = CLZ_CONTROL; dst = rd; end
          default:  ctrl = '0;
        endcase
      end
      OP_SPECIAL3: begin
        case (funct)
          F3_EXT: begin ctrl = EXT_CONTROL; dst = rt; end
          F3_INS: begin ctrl = INS_CONTROL; dst = rt; end
          F3_BSHFL: begin
            case (sa)
              SA_SEB:  begin ctrl = SEB_CONTROL;  dst = rd; end
              SA_SEH:  begin ctrl = SEH_CONTROL;  dst = rd; end
              SA_WSBH: begin ctrl = WSBH_CONTROL; dst = rd; end
              default: ctrl = '0;
            endcase
          end
          default: ctrl = '0;
        endcase
      end
      OP_ADDI:  begin ctrl = ADD_CONTROL;  dst = rt; end
      OP_ADDIU: begin ctrl = ADDU_CONTROL; dst = rt; end
      OP_SLTI:  begin ctrl = SLT_CONTROL;  dst = rt; end
      OP_SLTIU: begin ctrl = SLTU_CONTROL; dst = rt; end
      OP_ANDI:  begin ctrl = AND_CONTROL;  dst = rt; end
      OP_ORI:   begin ctrl = OR_CONTROL;   dst = rt; end
      OP_XORI:  begin ctrl = XOR_CONTROL;  dst = rt; end
      OP_LUI:   begin ctrl = LUI_CONTROL;  dst = rt; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: dst = rt;
      OP_JAL:   dst = 5'd31;
      default:  ctrl = '0;
    endcase
  end

  assign is_hilo = is_hilo_ctrl(ctrl);
  assign is_div  = (ctrl == DIV_CONTROL) || (ctrl == DIVU_CONTROL);

endmodule

// File: rtl/multi_issue_decode_buf.sv
// Instruction buffer between fetch and execute. Fetch pushes up to LANES
// instructions per cycle into a DEPTH-entry circular FIFO; the head LANES
// entries are decoded combinationally and offered to execute with a
// valid/ready handshake, subject to dual-issue pairing rules.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : discard all buffered instructions
//   in_valid/inst/pc: push side, lane 0 oldest, valid contiguous from lane 0
//   in_ready        : at least LANES free slots
//   out_valid/inst/pc/alucontrol/dst : issue side, data 0 on invalid lanes
//   issue_ready     : execute takes every valid lane this cycle
// Decode assumes 32-bit MIPS words, so XLEN and CTRL_W stay at 32 and 8.
module multi_issue_decode_buf
  import multi_issue_decode_buf_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DEPTH  = 8,
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*XLEN-1:0]   in_inst,
  input  logic [LANES*XLEN-1:0]   in_pc,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*XLEN-1:0]   out_inst,
  output logic [LANES*XLEN-1:0]   out_pc,
  output logic [LANES*CTRL_W-1:0] out_alucontrol,
  output logic [LANES*5-1:0]      out_dst,
  input  logic                    issue_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   push_n, pop_n;

  logic [CTRL_WP-1:0] dec_ctrl [LANES];
  logic [4:0]         dec_dst  [LANES];
  logic [4:0]         dec_rs   [LANES];
  logic [4:0]         dec_rt   [LANES];
  logic [LANES-1:0]   dec_hilo, dec_div;
  logic [LANES-1:0]   lane_ok;

  assign in_ready = (CW'(DEPTH) - count) >= CW'(LANES);

  // Head read, decode and output gating per lane.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PW-1:0] idx;
    lane_t         hd;

    assign idx = rd_ptr + PW'(l);

    inst_lane_decode u_dec (
      .inst    (mem_inst[idx]),
      .ctrl    (dec_ctrl[l]),
      .dst     (dec_dst[l]),
      .rs      (dec_rs[l]),
      .rt      (dec_rt[l]),
      .is_hilo (dec_hilo[l]),
      .is_div  (dec_div[l])
    );

    assign hd.inst = mem_inst[idx];
    assign hd.pc   = mem_pc[idx];
    assign hd.ctrl = dec_ctrl[l];
    assign hd.dst  = dec_dst[l];

    assign out_valid[l] = (count > CW'(l)) && lane_ok[l];

    assign out_inst[l*XLEN +: XLEN]         = out_valid[l] ? hd.inst : '0;
    assign out_pc[l*XLEN +: XLEN]           = out_valid[l] ? hd.pc   : '0;
    assign out_alucontrol[l*CTRL_W +: CTRL_W] = out_valid[l] ? hd.ctrl : '0;
    assign out_dst[l*5 +: 5]                = out_valid[l] ? hd.dst  : '0;
  end

  // Lane 1 issues only if it neither reads lane 0's result, nor competes for
  // HI/LO, nor trails a divide.
  if (LANES == 2) begin : g_pair
    logic raw_hazard, pair_ok;
    assign raw_hazard = (dec_dst[0] != 5'd0) &&
                        ((dec_rs[1] == dec_dst[0]) || (dec_rt[1] == dec_dst[0]));
    assign pair_ok    = !(raw_hazard || (dec_hilo[0] && dec_hilo[1]) || dec_div[0]);
    assign lane_ok    = {pair_ok, 1'b1};
  end else begin : g_single
    assign lane_ok = 1'b1;
  end

  always_comb begin
    push_n = '0;
    pop_n  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (in_ready && in_valid[l])     push_n = push_n + CW'(1);
      if (issue_ready && out_valid[l]) pop_n  = pop_n + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + push_n - pop_n;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never visible and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int l = 0; l < LANES; l++) begin
        if (in_ready && in_valid[l]) begin
          mem_inst[wr_ptr + PW'(l)] <= in_inst[l*XLEN +: XLEN];
          mem_pc[wr_ptr + PW'(l)]   <= in_pc[l*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_issue_decode_buf.sv
module tb_multi_issue_decode_buf;
  import multi_issue_decode_buf_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CTRL_W = 8;

  // Hand-assembled instructions
  localparam logic [31:0] I_ADD   = 32'h012A4020; // add  t0,t1,t2
  localparam logic [31:0] I_ORI   = 32'h358B0005; // ori  t3,t4,5
  localparam logic [31:0] I_ORIR  = 32'h350B0001; // ori  t3,t0,1
  localparam logic [31:0] I_SRL   = 32'h00094042; // srl  t0,t1,1
  localparam logic [31:0] I_ROTR  = 32'h00294042; // rotr t0,t1,1
  localparam logic [31:0] I_MULT  = 32'h012A0018; // mult t1,t2
  localparam logic [31:0] I_MFLO  = 32'h00004012; // mflo t0

  logic                    clk = 1'b0;
  logic                    rst, flush, issue_ready, in_ready;
  logic [LANES-1:0]        in_valid, out_valid;
  logic [LANES*XLEN-1:0]   in_inst, in_pc, out_inst, out_pc;
  logic [LANES*CTRL_W-1:0] out_alucontrol;
  logic [LANES*5-1:0]      out_dst;

  int tests = 0;
  int fails = 0;

  multi_issue_decode_buf #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_alucontrol(out_alucontrol), .out_dst(out_dst), .issue_ready(issue_ready)
  );

  always #5 clk = ~clk;

  // Stimulus protocol guard: lane 1 may never be valid without lane 0.
  always @(posedge clk) begin
    if (!rst) begin
      assert (in_valid != 2'b10) else begin
        fails++;
        $error("FAIL noncontig_in_valid: observed %b", in_valid);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1, input logic ir);
    in_valid    = v;
    in_inst     = {i1, i0};
    in_pc       = {p1, p0};
    issue_ready = ir;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ori_k(input int k);
    return 32'h3400_0000 | (32'(k) << 16) | 32'(k);
  endfunction

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 1'b0);

    // Reset held two cycles
    tick; tick;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    rst = 1'b0;
    issue_ready = 1'b1;
    tick;
    check("idle_out_valid", 64'(out_valid), 64'h0);
    check("idle_out_inst", 64'(out_inst), 64'h0);
    check("idle_in_ready", 64'(in_ready), 64'h1);

    // Independent pair issues together
    drive(2'b11, I_ADD, 32'h100, I_ORI, 32'h104, 1'b1);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b1);
    check("pair_valid", 64'(out_valid), 64'h3);
    check("pair_ctrl", 64'(out_alucontrol), 64'({OR_CONTROL, ADD_CONTROL}));
    check("pair_dst", 64'(out_dst), 64'({5'd11, 5'd8}));
    check("pair_pc", 64'(out_pc), {32'h104, 32'h100});
    tick;
    check("pair_popped", 64'(out_valid), 64'h0);

    // RAW dependency splits the pair
    drive(2'b11, I_ADD, 32'h200, I_ORIR, 32'h204, 1'b1);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b1);
    check("raw_valid", 64'(out_valid), 64'h1);
    check("raw_lane1_zero", 64'(out_inst[63:32]), 64'h0);
    check("raw_ctrl0", 64'(out_alucontrol[7:0]), 64'(ADD_CONTROL));
    tick;
    check("raw_second_valid", 64'(out_valid), 64'h1);
    check("raw_second_ctrl", 64'(out_alucontrol[7:0]), 64'(OR_CONTROL));
    check("raw_second_pc", 64'(out_pc[31:0]), 64'h204);
    check("raw_second_dst", 64'(out_dst[4:0]), 64'd11);
    tick;
    check("raw_drained", 64'(out_valid), 64'h0);

    // Shift vs rotate decode
    drive(2'b11, I_SRL, 32'h300, I_ROTR, 32'h304, 1'b0);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b0);
    check("shift_valid", 64'(out_valid), 64'h3);
    check("shift_ctrl", 64'(out_alucontrol), 64'({ROTR_CONTROL, SRL_CONTROL}));
    issue_ready = 1'b1;
    tick;
    check("shift_popped", 64'(out_valid), 64'h0);

    // Two HILO-class ops never pair
    drive(2'b11, I_MULT, 32'h310, I_MFLO, 32'h314, 1'b0);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b1);
    check("hilo_valid", 64'(out_valid), 64'h1);
    check("hilo_ctrl0", 64'(out_alucontrol[7:0]), 64'(MULT_CONTROL));
    check("hilo_dst0", 64'(out_dst[4:0]), 64'd0);
    tick;
    check("hilo_second_ctrl", 64'(out_alucontrol[7:0]), 64'(MFLO_CONTROL));
    check("hilo_second_dst", 64'(out_dst[4:0]), 64'd8);
    tick;
    check("hilo_drained", 64'(out_valid), 64'h0);

    // Offset pointers by one so the fill wraps
    drive(2'b01, ori_k(1), 32'h3FC, 0, 0, 1'b1);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b1);
    check("single_valid", 64'(out_valid), 64'h1);
    tick;

    // Fill with pairs while execute stalls
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, ori_k(2*k+1), 32'h400 + 32'(8*k), ori_k(2*k+2), 32'h404 + 32'(8*k), 1'b0);
      tick;
      drive(2'b00, 0, 0, 0, 0, 1'b0);
      check($sformatf("fill_in_ready_%0d", k), 64'(in_ready), (k < 3) ? 64'h1 : 64'h0);
    end
    drive(2'b11, 32'hDEAD0000, 32'hDEAD, 32'hDEAD0001, 32'hDEAE, 1'b0);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b1);
    check("full_in_ready", 64'(in_ready), 64'h0);
    check("full_head_pc", 64'(out_pc[31:0]), 64'h400);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_valid_%0d", k), 64'(out_valid), 64'h3);
      check($sformatf("drain_pc_%0d", k), 64'(out_pc),
            {32'h404 + 32'(8*k), 32'h400 + 32'(8*k)});
      tick;
    end
    check("drain_empty", 64'(out_valid), 64'h0);
    check("drain_in_ready", 64'(in_ready), 64'h1);

    // Count DEPTH-1 still blocks a push
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, ori_k(2*k+1), 32'h500 + 32'(8*k), ori_k(2*k+2), 32'h504 + 32'(8*k), 1'b0);
      tick;
    end
    drive(2'b01, ori_k(7), 32'h518, 0, 0, 1'b0);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b1);
    check("cnt7_in_ready", 64'(in_ready), 64'h0);
    check("cnt7_valid", 64'(out_valid), 64'h3);
    tick;
    check("cnt5_in_ready", 64'(in_ready), 64'h1);
    check("cnt5_head_pc", 64'(out_pc[31:0]), 64'h508);

    // Flush at count 5 with a simultaneous push and pop
    flush = 1'b1;
    drive(2'b11, ori_k(1), 32'h600, ori_k(2), 32'h604, 1'b1);
    tick;
    flush = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 1'b0);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_in_ready", 64'(in_ready), 64'h1);
    check("flush_out_pc", 64'(out_pc), 64'h0);
    drive(2'b11, ori_k(3), 32'h700, ori_k(4), 32'h704, 1'b0);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b1);
    check("post_flush_valid", 64'(out_valid), 64'h3);
    check("post_flush_pc", 64'(out_pc), {32'h704, 32'h700});
    tick;
    check("post_flush_drained", 64'(out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
